// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the CHIP-8 RAM arbiter: default geometry, owner codes and FSM states.
package mem_arbiter_pkg;

  localparam int DEF_ADDR_W  = 12;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_FB_BASE = 'h100;
  localparam int DEF_FB_SIZE = 'h100;

  // Owner codes double as bit indices into the request vector.
  localparam logic [1:0] OWN_DISP = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_GPU  = 2'd2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection: scanout has absolute priority, CPU/GPU share by 2-way round-robin.
module mem_arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] rr_last,
  output logic       grant,
  output logic [1:0] winner
);

  always_comb begin
    grant  = |req;
    winner = OWN_DISP;
    if (req[OWN_DISP]) begin
      winner = OWN_DISP;
    end else if (req[OWN_CPU] && req[OWN_GPU]) begin
      winner = (rr_last == OWN_CPU) ? OWN_GPU : OWN_CPU;
    end else if (req[OWN_CPU]) begin
      winner = OWN_CPU;
    end else if (req[OWN_GPU]) begin
      winner = OWN_GPU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for scanout, CPU and GPU; one access in flight, fixed 3-cycle turn.
//
// state    | meaning
// ST_IDLE  | sample requests, latch winner
// ST_ISSUE | drive RAM strobe from the latched request
// ST_RESP  | pulse owner ack, pass RAM data through
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int FB_BASE = DEF_FB_BASE,
  parameter int FB_SIZE = DEF_FB_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_fault,
  input  logic              gpu_req,
  input  logic              gpu_we,
  input  logic [ADDR_W-1:0] gpu_addr,
  input  logic [DATA_W-1:0] gpu_wdata,
  output logic              gpu_ack,
  output logic [DATA_W-1:0] gpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // Extra MSB keeps FB_BASE+FB_SIZE from wrapping at the top of the map.
  localparam logic [ADDR_W:0] FB_LO  = (ADDR_W+1)'(FB_BASE);
  localparam logic [ADDR_W:0] FB_END = (ADDR_W+1)'(FB_BASE + FB_SIZE);

  logic [1:0]        state;
  logic [1:0]        rr_last;
  logic [1:0]        lat_own;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic              grant;
  logic [1:0]        winner;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              protect;
  logic              resp;

  mem_arb_pick u_pick (
    .req     ({gpu_req, cpu_req, disp_req}),
    .rr_last (rr_last),
    .grant   (grant),
    .winner  (winner)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = disp_addr;
    sel_wdata = '0;
    case (winner)
      OWN_CPU: begin
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
      end
      OWN_GPU: begin
        sel_we    = gpu_we;
        sel_addr  = gpu_addr;
        sel_wdata = gpu_wdata;
      end
      default: ;
    endcase
  end

  assign protect = (lat_own == OWN_CPU) && lat_we &&
                   ({1'b0, lat_addr} >= FB_LO) && ({1'b0, lat_addr} < FB_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rr_last   <= OWN_GPU;
      lat_own   <= OWN_DISP;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cpu_fault <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            lat_own   <= winner;
            lat_we    <= sel_we;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            if (winner != OWN_DISP) rr_last <= winner;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_RESP;
        ST_RESP: begin
          if (protect) cpu_fault <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign mem_en    = (state == ST_ISSUE);
  assign mem_we    = mem_en && lat_we && !protect;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  assign resp       = (state == ST_RESP);
  assign disp_ack   = resp && (lat_own == OWN_DISP);
  assign cpu_ack    = resp && (lat_own == OWN_CPU);
  assign gpu_ack    = resp && (lat_own == OWN_GPU);
  assign disp_rdata = disp_ack ? mem_rdata : '0;
  assign cpu_rdata  = cpu_ack  ? mem_rdata : '0;
  assign gpu_rdata  = gpu_ack  ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a synchronous RAM model behind it.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        disp_req = 1'b0;
  logic [11:0] disp_addr = '0;
  logic        disp_ack;
  logic [7:0]  disp_rdata;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack, cpu_fault;
  logic [7:0]  cpu_rdata;
  logic        gpu_req = 1'b0, gpu_we = 1'b0;
  logic [11:0] gpu_addr = '0;
  logic [7:0]  gpu_wdata = '0;
  logic        gpu_ack;
  logic [7:0]  gpu_rdata;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic [7:0]  ram [0:4095];
  logic [7:0]  exp_mem [0:4095];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;

  int          cyc = 0;
  int          nlog = 0;
  logic [1:0]  own_log [0:31];
  int          cyc_log [0:31];
  logic [7:0]  dat_log [0:31];

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack), .disp_rdata(disp_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_fault(cpu_fault),
    .gpu_req(gpu_req), .gpu_we(gpu_we), .gpu_addr(gpu_addr), .gpu_wdata(gpu_wdata),
    .gpu_ack(gpu_ack), .gpu_rdata(gpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pl_en) ram[pl_addr] <= pl_data;
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  always @(negedge clk) begin
    if ((disp_ack || cpu_ack || gpu_ack) && nlog < 32) begin
      own_log[nlog] <= disp_ack ? OWN_DISP : (cpu_ack ? OWN_CPU : OWN_GPU);
      dat_log[nlog] <= disp_ack ? disp_rdata : (cpu_ack ? cpu_rdata : gpu_rdata);
      cyc_log[nlog] <= cyc;
      nlog <= nlog + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One tick; any requester acked in this cycle releases its request.
  task automatic step_drop();
    tick();
    if (disp_ack) disp_req = 1'b0;
    if (cpu_ack)  cpu_req  = 1'b0;
    if (gpu_ack)  gpu_req  = 1'b0;
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic xact(input logic [1:0] who, input logic we, input logic [11:0] a,
                      input logic [7:0] d, output logic [7:0] rd, output logic saw_we);
    int  n;
    logic acked;
    case (who)
      OWN_DISP: begin disp_req = 1'b1; disp_addr = a; end
      OWN_CPU:  begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
      default:  begin gpu_req = 1'b1; gpu_we = we; gpu_addr = a; gpu_wdata = d; end
    endcase
    n = 0; acked = 1'b0; saw_we = 1'b0; rd = '0;
    while (!acked && n < 8) begin
      tick();
      n++;
      if (mem_en) saw_we = mem_we;
      case (who)
        OWN_DISP: begin acked = disp_ack; rd = disp_rdata; end
        OWN_CPU:  begin acked = cpu_ack;  rd = cpu_rdata;  end
        default:  begin acked = gpu_ack;  rd = gpu_rdata;  end
      endcase
    end
    if (!acked) chk("ack_timeout", 32'(n), 32'd2);
    else        chk("ack_latency", 32'(n), 32'd2);
    disp_req = 1'b0; cpu_req = 1'b0; gpu_req = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic       swe;
    int         nbad;

    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_outputs", {29'd0, disp_ack, cpu_ack, gpu_ack}, 32'd0);
    chk("rst_mem", {mem_en, mem_we, busy, cpu_fault, 8'd0, mem_addr, mem_wdata}, 32'd0);

    // 1: reset lands in the ISSUE cycle of a GPU write
    poke(12'h150, 8'h5A);
    nlog = 0;
    gpu_req = 1'b1; gpu_we = 1'b1; gpu_addr = 12'h150; gpu_wdata = 8'hAA;
    tick();
    chk("t1_issue_en", {mem_en, mem_we}, 2'b11);
    rst = 1'b1;
    #1;
    chk("t1_rst_drop", {mem_en, mem_we, busy}, 3'b000);
    gpu_req = 1'b0; gpu_we = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("t1_no_ack", 32'(nlog), 32'd0);
    chk("t1_ram", ram[12'h150], 8'h5A);
    chk("t1_outputs", {disp_ack, cpu_ack, gpu_ack, mem_en, mem_we, busy, cpu_fault}, 7'd0);
    chk("t1_addr_data", {mem_addr, mem_wdata}, 20'd0);

    // 2: CPU read timing
    poke(12'h200, 8'h5C);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h200;
    tick();
    chk("t2_issue", {mem_en, mem_we, busy, mem_addr}, {3'b101, 12'h200});
    tick();
    chk("t2_ack", {cpu_ack, gpu_ack, disp_ack, cpu_rdata}, {3'b100, 8'h5C});
    cpu_req = 1'b0;
    tick();
    chk("t2_idle", {busy, cpu_ack, mem_en}, 3'b000);

    // 3: CPU and GPU held continuously from reset
    do_reset();
    poke(12'h010, 8'hC1);
    poke(12'h020, 8'h62);
    nlog = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
    gpu_req = 1'b1; gpu_we = 1'b0; gpu_addr = 12'h020;
    repeat (12) tick();
    cpu_req = 1'b0; gpu_req = 1'b0;
    repeat (3) tick();
    chk("t3_count", 32'(nlog), 32'd4);
    chk("t3_order", {own_log[0], own_log[1], own_log[2], own_log[3]},
        {OWN_CPU, OWN_GPU, OWN_CPU, OWN_GPU});
    chk("t3_gap", {8'(cyc_log[1]-cyc_log[0]), 8'(cyc_log[2]-cyc_log[1]), 8'(cyc_log[3]-cyc_log[2])},
        {8'd3, 8'd3, 8'd3});
    chk("t3_data", {dat_log[0], dat_log[1], dat_log[2], dat_log[3]}, 32'hC162C162);

    // 4: all three at once, released on ack
    do_reset();
    nlog = 0;
    disp_req = 1'b1; disp_addr = 12'h030;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h040;
    gpu_req = 1'b1; gpu_we = 1'b0; gpu_addr = 12'h050;
    repeat (11) step_drop();
    chk("t4_count", 32'(nlog), 32'd3);
    chk("t4_order", {own_log[0], own_log[1], own_log[2]}, {OWN_DISP, OWN_CPU, OWN_GPU});
    chk("t4_gap", {8'(cyc_log[1]-cyc_log[0]), 8'(cyc_log[2]-cyc_log[1])}, {8'd3, 8'd3});

    // 5: framebuffer write protect and its boundaries
    poke(12'h1FF, 8'h77);
    poke(12'h100, 8'h66);
    poke(12'h0FF, 8'h55);
    chk("t5_fault_pre", cpu_fault, 1'b0);
    xact(OWN_CPU, 1'b1, 12'h1FF, 8'h11, rd, swe);
    chk("t5_1ff_we", swe, 1'b0);
    chk("t5_1ff_fault", cpu_fault, 1'b1);
    chk("t5_1ff_ram", ram[12'h1FF], 8'h77);
    xact(OWN_CPU, 1'b1, 12'h200, 8'h22, rd, swe);
    chk("t5_200_ram", ram[12'h200], 8'h22);
    xact(OWN_CPU, 1'b1, 12'h0FF, 8'h44, rd, swe);
    chk("t5_0ff_ram", ram[12'h0FF], 8'h44);
    xact(OWN_CPU, 1'b1, 12'h100, 8'h99, rd, swe);
    chk("t5_100_ram", ram[12'h100], 8'h66);
    xact(OWN_GPU, 1'b1, 12'h100, 8'h33, rd, swe);
    chk("t5_gpu_ram", ram[12'h100], 8'h33);
    chk("t5_fault_sticky", cpu_fault, 1'b1);

    // 6: random single transactions against a shadow image
    for (int i = 0; i < 4096; i++) exp_mem[i] = ram[i];
    for (int i = 0; i < 300; i++) begin
      logic [1:0]  who;
      logic        we;
      logic [11:0] a;
      logic [7:0]  d;
      who = 2'($urandom_range(0, 2));
      we  = (who == OWN_DISP) ? 1'b0 : 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 1) == 1) ? 12'($urandom_range('h0F0, 'h210)) : 12'($urandom_range(0, 4095));
      d   = 8'($urandom_range(0, 255));
      xact(who, we, a, d, rd, swe);
      if (!we) chk("rnd_read", rd, exp_mem[a]);
      else if (!(who == OWN_CPU && a >= 12'h100 && a <= 12'h1FF)) exp_mem[a] = d;
    end
    nbad = 0;
    for (int i = 0; i < 4096; i++) if (ram[i] !== exp_mem[i]) nbad++;
    chk("rnd_mem_image", 32'(nbad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
